uart_tx: RTL and testbench
==========================

# uart_tx

Serial 8N1 UART transmitter that drains the UART TX byte FIFO and drives the `tx` pin. It pops one byte whenever the FIFO is non-empty and the transmitter is idle. It then shifts the byte out as start bit, 8 data bits LSB first, and stop bit, with bit timing derived from an internal 16x oversample baud tick. It sits directly downstream of the TX FIFO, between the FIFO read port and the board pin.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000: system clock frequency, Hz.
- `BAUD_RATE`, 9600: line rate, bit/s.
- Derived `DIV = CLK_FREQ / (BAUD_RATE*16)`: integer truncation, must be >= 1; clk cycles per oversample tick.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rdata`  in  8  FIFO head byte; combinational, valid whenever `fifo_empty`=0.
- `fifo_rd_en`  out  1  pop strobe to FIFO.
- `tx`  out  1  serial line, idle high.
- `tx_busy`  out  1  frame in progress.
- `tx_done`  out  1  one-cycle pulse, frame complete.

## Operation
- States: IDLE, START, DATA, STOP.
- **IDLE**
  - `tx`=1.
  - If `fifo_empty`=0: assert `fifo_rd_en` (combinational, IDLE && !fifo_empty), latch `fifo_rdata` into the shift register, clear the bit index and tick counter, clear the baud divider, and go to START.
- **START**
  - `tx`=0 for 16 ticks, then go to DATA.
- **DATA**
  - `tx` = shift[0] for 16 ticks, then shift right.
  - Bit index counts 0..7; after bit 7, go to STOP.
- **STOP**
  - `tx`=1 for 16 ticks, then go to IDLE and pulse `tx_done`.
- **Baud divider**
  - Counter 0..DIV-1; `tick` is high when the count equals DIV-1, then the counter wraps.
  - Synchronous clear from the FSM on frame start, so every bit lasts exactly 16*DIV cycles.
- Tick counter is 4 bits and wraps at 15; the state or bit advances on the tick where the count equals 15.
- `tx`, `tx_busy` and `tx_done` are registered outputs.
- `tx_busy`=1 in START, DATA and STOP.
- **Boundary conditions**
  - FIFO becomes non-empty mid-frame: ignored until IDLE; never pop outside IDLE.
  - Exactly one pop per frame. `fifo_rd_en` drops the cycle after the pop because the state has left IDLE, so the FIFO's registered `empty` update cannot cause a double pop.
  - Back-to-back bytes: the first IDLE cycle after STOP may pop immediately, in the same cycle as `tx_done`=1.
  - `fifo_rdata` changing after the pop has no effect; the byte is already latched.
  - Reset mid-frame:
    - Outputs immediately return to `tx`=1, `tx_busy`=0, `tx_done`=0.
    - FSM goes to IDLE and the divider and counters clear.
    - The in-flight byte is dropped, not re-popped.
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, `fifo_rd_en`=0 (FIFO reset drives empty=1), state IDLE, shift register 0.

## Timing
- Cycle t: IDLE with `fifo_empty`=0, so `fifo_rd_en`=1.
- Cycle t+1: `tx`=0 and `tx_busy`=1.
- Start bit: cycles t+1 .. t+16*DIV.
- Data bit k: starts at t+1+16*DIV*(k+1).
- Stop bit: starts at t+1+16*DIV*9.
- Cycle t+1+160*DIV: `tx_done`=1 and `tx_busy`=0 for that single cycle; a new pop is allowed in this same cycle.
- Back-to-back throughput: 160*DIV+1 cycles per byte.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding localparams (IDLE=0, START=1, DATA=2, STOP=3);
  - `OVERSAMPLE`=16;
  - `DATA_BITS`=8.
- These constants are reused by the future `uart_rx`.
- Sub-module `baud_tick_gen`:
  - Ports: clk, reset, clear, tick.
  - Parameter: DIV.
  - The same sub-module is reused by RX.
- Top `uart_tx` contains the FSM, tick counter, bit index and shift register.

## Test plan
Bench parameters: CLK_FREQ=1_600_000 and BAUD_RATE=100_000, giving DIV=1 and 16 cycles per bit. All tests use a FIFO model with combinational read data.

- **Reset:** hold `reset` for 3 cycles -> `tx`=1, `tx_busy`=0, `tx_done`=0, `fifo_rd_en`=0 throughout, and stay so with `fifo_empty`=1.
- **Single byte 0xA5:** FIFO holds 0xA5 -> `fifo_rd_en` high exactly 1 cycle. `tx` then shows 0 for 16 cycles, bits 1,0,1,0,0,1,0,1 at 16 cycles each, then 1 for 16 cycles. `tx_done` pulses at cycle 161 after the pop.
- **Back-to-back 0x00, 0xFF, 0x55 preloaded:**
  - pops occur exactly 161 cycles apart;
  - each pop coincides with the previous `tx_done`;
  - the receiver model decodes 0x00, 0xFF, 0x55 in order.
- **Write during frame:** push 0x3C while 0x81 is mid-DATA -> no `fifo_rd_en` until `tx_done`. Then 0x3C is popped that cycle and transmitted intact.
- **Reset mid-frame:** assert `reset` during data bit 4 of 0xC3 -> `tx`=1 and `tx_busy`=0 immediately. After release with the FIFO empty: no pop and the line stays idle.
- **Real divider:** default CLK_FREQ/BAUD_RATE -> DIV=651, and every bit measures exactly 10416 cycles for byte 0x4B.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and state encoding, common to the transmitter and
// the receiver.
package uart_pkg;

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_START = 2'd1;
  localparam logic [1:0] STATE_DATA  = 2'd2;
  localparam logic [1:0] STATE_STOP  = 2'd3;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int OS_W       = $clog2(OVERSAMPLE);
  localparam int BIT_W      = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    IDLE  = STATE_IDLE,
    START = STATE_START,
    DATA  = STATE_DATA,
    STOP  = STATE_STOP
  } uart_state_e;

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks, with a
// synchronous clear so a frame can start on a fresh tick boundary.
module baud_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Divider next-count and tick decode.
  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Divider count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: pops one byte from the TX FIFO when idle and
// serialises it as start bit, eight data bits LSB first, and stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);

  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic                 tx_q, tx_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_done_q, tx_done_d;
  logic                 tick;
  logic                 div_clear;
  logic                 bit_end;

  baud_tick_gen #(
    .DIV (DIV)
  ) u_baud_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (div_clear),
    .tick  (tick)
  );

  // Frame sequencing, pop strobe and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    os_cnt_d   = os_cnt_q;
    div_clear  = 1'b0;
    fifo_rd_en = 1'b0;
    tx_done_d  = 1'b0;
    bit_end    = tick && (os_cnt_q == OS_LAST);

    if ((state_q != IDLE) && tick) begin
      os_cnt_d = os_cnt_q + OS_W'(1);
    end else begin
      os_cnt_d = os_cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          shift_d    = fifo_rdata;
          bit_idx_d  = '0;
          os_cnt_d   = '0;
          div_clear  = 1'b1;
          state_d    = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d   = IDLE;
          tx_done_d = 1'b1;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the next state.
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    tx_busy_d = (state_d != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      os_cnt_q  <= '0;
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      os_cnt_q  <= os_cnt_d;
      tx_q      <= tx_d;
      tx_busy_q <= tx_busy_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a queue-based FIFO model feeds the DUT and every line
// cycle is compared with the frame shape computed from the byte value.
module tb_uart_tx;

  localparam int BIT_CYC  = 16;
  localparam int FRAME    = 10 * BIT_CYC;
  localparam int REAL_BIT = 10416;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_rd_en, tx, tx_busy, tx_done;

  logic       fifo2_empty = 1'b1;
  logic [7:0] fifo2_rdata = 8'h00;
  logic       fifo2_rd_en, tx2, tx2_busy, tx2_done;

  logic [7:0] fifo_q[$];
  int         n_vec = 0;
  int         n_miscmp = 0;
  logic       s_tx, s_busy, s_done, last_rd, last_avail;

  always #5 clk = ~clk;

  uart_tx #(
    .CLK_FREQ  (1_600_000),
    .BAUD_RATE (100_000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  uart_tx dut_real (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo2_empty),
    .fifo_rdata (fifo2_rdata),
    .fifo_rd_en (fifo2_rd_en),
    .tx         (tx2),
    .tx_busy    (tx2_busy),
    .tx_done    (tx2_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic fifo_sync();
    if (fifo_q.size() != 0) begin
      fifo_empty = 1'b0;
      fifo_rdata = fifo_q[0];
    end else begin
      fifo_empty = 1'b1;
      fifo_rdata = 8'h00;
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_sync();
  endtask

  // Sample one cycle at the falling edge; apply any pop just after the rise.
  task automatic run_cycle();
    logic [7:0] dummy;
    @(negedge clk);
    s_tx       = tx;
    s_busy     = tx_busy;
    s_done     = tx_done;
    last_rd    = fifo_rd_en;
    last_avail = !fifo_empty;
    @(posedge clk);
    #1;
    if (last_rd && (fifo_q.size() != 0)) begin
      dummy = fifo_q.pop_front();
    end
    fifo_sync();
  endtask

  // Expected line level k cycles after the pop cycle (k starts at 1).
  function automatic logic model_line(input logic [7:0] b, input int k, input int bit_cyc);
    int slot;
    slot = (k - 1) / bit_cyc;
    if (slot == 0) return 1'b0;
    else if (slot <= 8) return b[slot-1];
    else return 1'b1;
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, "_tx"}, 32'(s_tx), 32'd1);
    check_eq({tag, "_busy"}, 32'(s_busy), 32'd0);
    check_eq({tag, "_done"}, 32'(s_done), 32'd0);
  endtask

  task automatic wait_pop();
    int n = 0;
    while (!last_rd && n < 400) begin
      run_cycle();
      check_eq("wait_tx", 32'(s_tx), 32'd1);
      check_eq("wait_busy", 32'(s_busy), 32'd0);
      n++;
    end
    check_eq("pop_seen", 32'(last_rd), 32'd1);
  endtask

  // Follow one frame from the cycle after its pop through the tx_done cycle.
  task automatic check_frame(input logic [7:0] b, input int push_at,
                             input logic [7:0] push_val, input int abort_at);
    logic [7:0] rx;
    int         slot;
    rx = 8'h00;
    for (int k = 1; k <= FRAME + 1; k++) begin
      if (k == abort_at) return;
      run_cycle();
      if (k <= FRAME) begin
        check_eq("tx_line", 32'(s_tx), 32'(model_line(b, k, BIT_CYC)));
        check_eq("busy_in_frame", 32'(s_busy), 32'd1);
        check_eq("done_in_frame", 32'(s_done), 32'd0);
        check_eq("pop_in_frame", 32'(last_rd), 32'd0);
        slot = (k - 1) / BIT_CYC;
        if (((k - 1) % BIT_CYC == BIT_CYC / 2) && (slot >= 1) && (slot <= 8)) begin
          rx[slot-1] = s_tx;
        end
      end else begin
        check_eq("done_pulse", 32'(s_done), 32'd1);
        check_eq("busy_at_done", 32'(s_busy), 32'd0);
        check_eq("tx_at_done", 32'(s_tx), 32'd1);
        check_eq("pop_at_done", 32'(last_rd), 32'(last_avail));
        check_eq("rx_byte", 32'(rx), 32'(b));
      end
      if (k == push_at) push(push_val);
    end
  endtask

  initial begin
    logic [7:0] rb;
    int         slot, off;
    last_rd = 1'b0;
    fifo_sync();

    // Reset held for three cycles, then idle with an empty FIFO.
    repeat (3) begin
      run_cycle();
      check_idle("reset");
      check_eq("reset_rd", 32'(last_rd), 32'd0);
    end
    reset = 1'b0;
    repeat (5) begin
      run_cycle();
      check_idle("post_reset");
      check_eq("post_reset_rd", 32'(last_rd), 32'd0);
    end

    // Single byte.
    push(8'hA5);
    wait_pop();
    check_frame(8'hA5, 0, 8'h00, 0);

    // Back-to-back preloaded bytes.
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    wait_pop();
    check_frame(8'h00, 0, 8'h00, 0);
    check_frame(8'hFF, 0, 8'h00, 0);
    check_frame(8'h55, 0, 8'h00, 0);

    // A byte arriving mid-frame waits for the tx_done cycle.
    push(8'h81);
    wait_pop();
    check_frame(8'h81, 50, 8'h3C, 0);
    check_frame(8'h3C, 0, 8'h00, 0);

    // Random bytes with random idle gaps.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 6)) begin
        run_cycle();
        check_idle("gap");
      end
      rb = 8'($urandom);
      push(rb);
      wait_pop();
      check_frame(rb, 0, 8'h00, 0);
    end

    // Reset during data bit 4 of 0xC3 (line low there).
    push(8'hC3);
    wait_pop();
    check_frame(8'hC3, 0, 8'h00, 5 * BIT_CYC + 8);
    reset = 1'b1;
    #2;
    check_eq("async_reset_tx", 32'(tx), 32'd1);
    check_eq("async_reset_busy", 32'(tx_busy), 32'd0);
    check_eq("async_reset_done", 32'(tx_done), 32'd0);
    repeat (2) run_cycle();
    reset = 1'b0;
    repeat (200) begin
      run_cycle();
      check_idle("after_abort");
      check_eq("after_abort_rd", 32'(last_rd), 32'd0);
    end

    // Default parameters: 651-cycle tick, 10416 cycles per bit, byte 0x4B.
    fifo2_empty = 1'b0;
    fifo2_rdata = 8'h4B;
    @(negedge clk);
    check_eq("real_pop", 32'(fifo2_rd_en), 32'd1);
    check_eq("real_idle_tx", 32'(tx2), 32'd1);
    @(posedge clk);
    #1;
    fifo2_empty = 1'b1;
    fifo2_rdata = 8'hEE;
    for (int k = 1; k <= 5 * REAL_BIT + 1; k++) begin
      @(negedge clk);
      slot = (k - 1) / REAL_BIT;
      off  = (k - 1) % REAL_BIT;
      if ((off == 0) || (off == REAL_BIT / 2) || (off == REAL_BIT - 1)) begin
        check_eq("real_tx", 32'(tx2), 32'(model_line(8'h4B, k, REAL_BIT)));
        check_eq("real_busy", 32'(tx2_busy), 32'd1);
        check_eq("real_no_pop", 32'(fifo2_rd_en), 32'd0);
      end
      if ((k == 1) && (slot == 0)) begin
        check_eq("real_done_low", 32'(tx2_done), 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
